// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the mem_ctrl IF/MEM responder.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_t;

   localparam logic [1:0]  SIZE_B     = 2'd0;
   localparam logic [1:0]  SIZE_H     = 2'd1;
   localparam logic [1:0]  SIZE_W     = 2'd2;
   localparam logic [1:0]  IO_ADDR_HI = 2'b11;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic [2:0]  WORD_LEN   = 3'd4;

   // Byte count of a MEM access; the unused size code 3 behaves as a word.
   function automatic logic [2:0] xfer_len(input logic [1:0] size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         SIZE_W:  return WORD_LEN;
         default: return WORD_LEN;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Byte lane steering: merges a read byte into the word accumulator and
// selects the write byte for the current byte index.
module mem_byte_assembler #(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        idx,
   input  logic [7:0]        rd_byte,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] acc_next,
   output logic [7:0]        wr_byte
);

   always_comb begin
      acc_next              = acc;
      acc_next[8*idx +: 8]  = rd_byte;
      wr_byte               = wdata[8*idx +: 8];
   end

endmodule

// File: rtl/mem_ctrl.sv
// IF/MEM responder serialising accesses onto a byte-wide synchronous RAM.
// Optional IO-full write stall enabled by defining MEM_CTRL_IO_FULL_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   input  logic              branch_flag_in,
   output logic [DATA_W-1:0] inst_out,
   output logic              inst_done_out,
   input  logic              mem_req_in,
   input  logic              mem_we_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [1:0]        mem_size_in,
   input  logic [DATA_W-1:0] mem_wdata_in,
   output logic [DATA_W-1:0] mem_rdata_out,
   output logic              mem_done_out,
   output logic [1:0]        busy_out,
   input  logic [7:0]        ram_din_in,
   output logic [7:0]        ram_dout_out,
   output logic [ADDR_W-1:0] ram_a_out,
   output logic              ram_wr_out,
   input  logic              io_full_in
);

   state_t            state, next_state;
   logic [2:0]        cnt, len;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] wdata, acc, acc_next;
   logic [7:0]        wr_byte;
   logic [1:0]        idx;
   logic              take_mem, take_if;
   logic              rd_done, wr_done, abort, free, capture, stall;

   // Reads need two extra cycles: RAM latency plus the registered result.
   assign rd_done = (state == IF_RD || state == MEM_RD) && (cnt == len + 3'd1);
   assign wr_done = (state == MEM_WR) && (cnt == len);
   assign abort   = (state == IF_RD) && branch_flag_in;
   assign free    = (state == IDLE) || ((rd_done || wr_done) && !abort);
   assign capture = (state == IF_RD || state == MEM_RD) && (cnt != 3'd0) && (cnt <= len);
   assign idx     = (state == MEM_WR) ? cnt[1:0] : (cnt[1:0] - 2'd1);

`ifdef MEM_CTRL_IO_FULL_EN
   assign stall = (state == MEM_WR) && (base[17:16] == IO_ADDR_HI) && io_full_in && (cnt < len);
`else
   logic unused_io_full;
   assign unused_io_full = io_full_in;
   assign stall          = 1'b0;
`endif

   mem_byte_assembler #(.DATA_W(DATA_W)) u_asm (
      .idx      (idx),
      .rd_byte  (ram_din_in),
      .acc      (acc),
      .wdata    (wdata),
      .acc_next (acc_next),
      .wr_byte  (wr_byte)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt   <= '0;
         len   <= '0;
         base  <= '0;
         wdata <= '0;
         acc   <= '0;
      end else if (take_mem || take_if) begin
         cnt   <= '0;
         len   <= take_mem ? xfer_len(mem_size_in) : WORD_LEN;
         base  <= take_mem ? mem_addr_in : if_addr_in;
         wdata <= mem_wdata_in;
         acc   <= '0;
      end else begin
         if (capture) begin
            acc <= acc_next;
         end
         if (next_state == IDLE) begin
            cnt <= '0;
         end else if (!stall) begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   always_comb begin
      next_state    = state;
      take_mem      = 1'b0;
      take_if       = 1'b0;
      inst_out      = '0;
      inst_done_out = 1'b0;
      mem_rdata_out = '0;
      mem_done_out  = 1'b0;
      busy_out      = 2'b00;
      ram_a_out     = '0;
      ram_wr_out    = 1'b0;
      ram_dout_out  = 8'h00;

      if (state == IF_RD && rd_done && !branch_flag_in) begin
         inst_done_out = 1'b1;
         inst_out      = acc;
      end
      if (state == MEM_RD && rd_done) begin
         mem_done_out  = 1'b1;
         mem_rdata_out = acc;
      end
      if (wr_done) begin
         mem_done_out = 1'b1;
      end
      busy_out[1] = (state == IF_RD) && !inst_done_out;
      busy_out[0] = (state == MEM_RD || state == MEM_WR) && !mem_done_out;

      if (state != IDLE && cnt < len) begin
         ram_a_out = base + ADDR_W'(cnt);
         if (state == MEM_WR) begin
            ram_wr_out   = !stall;
            ram_dout_out = wr_byte;
         end
      end

      // The done cycle doubles as an idle cycle so back-to-back requests see no bubble.
      if (free) begin
         if (mem_req_in) begin
            take_mem   = 1'b1;
            next_state = mem_we_in ? MEM_WR : MEM_RD;
         end else if (if_req_in && !branch_flag_in) begin
            take_if    = 1'b1;
            next_state = IF_RD;
         end else begin
            next_state = IDLE;
         end
      end else if (abort) begin
         next_state = IDLE;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-array reference memory.
module tb_mem_ctrl;

`ifdef MEM_CTRL_IO_FULL_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        if_req_in = 1'b0;
   logic [31:0] if_addr_in = '0;
   logic        branch_flag_in = 1'b0;
   logic [31:0] inst_out;
   logic        inst_done_out;
   logic        mem_req_in = 1'b0;
   logic        mem_we_in = 1'b0;
   logic [31:0] mem_addr_in = '0;
   logic [1:0]  mem_size_in = '0;
   logic [31:0] mem_wdata_in = '0;
   logic [31:0] mem_rdata_out;
   logic        mem_done_out;
   logic [1:0]  busy_out;
   logic [7:0]  ram_din_in;
   logic [7:0]  ram_dout_out;
   logic [31:0] ram_a_out;
   logic        ram_wr_out;
   logic        io_full_in = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] ram_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in), .branch_flag_in(branch_flag_in),
      .inst_out(inst_out), .inst_done_out(inst_done_out),
      .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in),
      .mem_size_in(mem_size_in), .mem_wdata_in(mem_wdata_in),
      .mem_rdata_out(mem_rdata_out), .mem_done_out(mem_done_out), .busy_out(busy_out),
      .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out), .ram_a_out(ram_a_out),
      .ram_wr_out(ram_wr_out), .io_full_in(io_full_in)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
      return v;
   endfunction

   function automatic int len_of(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   // Synchronous byte RAM: data for the address of one cycle appears the next.
   always @(posedge clk_in) begin
      if (ram_wr_out) ram_mem[ram_a_out] = ram_dout_out;
      ram_din_in <= ram_rd(ram_a_out);
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram_mem[a] = b;
      ref_mem[a] = b;
   endtask

   task automatic test_reset();
      if_req_in  = 1'b1;
      mem_req_in = 1'b1;
      #3 rst_in = 1'b0;
      tick();
      tick();
      vectors++;
      if ({inst_out, inst_done_out, mem_rdata_out, mem_done_out, busy_out, ram_dout_out, ram_a_out, ram_wr_out} !== '0)
         begin miscompares++; $display("[TB] FAIL reset_outputs got busy=%b ram_a=%h wr=%b want all zero", busy_out, ram_a_out, ram_wr_out); end
      if_req_in  = 1'b0;
      mem_req_in = 1'b0;
      rst_in     = 1'b1;
      tick();
      vectors++;
      if (busy_out !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_idle got %b want 00", busy_out); end
   endtask

   task automatic test_if_read();
      logic [31:0] a, exp;
      int cyc;
      bit got;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            a = 32'h0000_1000;
            preload(a, 8'h13); preload(a + 1, 8'h00); preload(a + 2, 8'h00); preload(a + 3, 8'h00);
         end else begin
            a = (i == 1) ? 32'hFFFF_FFFE : (($urandom & 32'h0000_0FFC) | 32'h0000_4000);
            for (int k = 0; k < 4; k++) preload(a + 32'(k), 8'($urandom));
         end
         exp = (i == 0) ? 32'h0000_0013 : ref_load(a, 4);
         if_addr_in = a;
         if_req_in  = 1'b1;
         cyc = 0;
         got = 1'b0;
         while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (inst_done_out) begin
               got = 1'b1;
               if_req_in = 1'b0;
            end else begin
               vectors++;
               if (busy_out !== 2'b10 || inst_out !== 32'h0)
                  begin miscompares++; $display("[TB] FAIL if_busy cyc %0d got %b/%h want 10/0", cyc, busy_out, inst_out); end
               if (cyc <= 4) begin
                  vectors++;
                  if (ram_a_out !== a + 32'(cyc - 1) || ram_wr_out !== 1'b0)
                     begin miscompares++; $display("[TB] FAIL if_ram_addr got %h/%b want %h/0", ram_a_out, ram_wr_out, a + 32'(cyc - 1)); end
               end
            end
         end
         if_req_in = 1'b0;
         vectors++;
         if (!got || cyc != 6) begin miscompares++; $display("[TB] FAIL if_latency got %0d want 6", cyc); end
         vectors++;
         if (inst_out !== exp) begin miscompares++; $display("[TB] FAIL if_data got %h want %h", inst_out, exp); end
      end
      tick();
   endtask

   task automatic test_store_byte();
      mem_we_in    = 1'b1;
      mem_addr_in  = 32'h3;
      mem_size_in  = 2'd0;
      mem_wdata_in = 32'h1234_56AB;
      mem_req_in   = 1'b1;
      tick();
      vectors++;
      if (ram_wr_out !== 1'b1 || ram_a_out !== 32'h3 || ram_dout_out !== 8'hAB || mem_done_out !== 1'b0)
         begin miscompares++; $display("[TB] FAIL sb_write got wr=%b a=%h d=%h want 1/3/ab", ram_wr_out, ram_a_out, ram_dout_out); end
      tick();
      vectors++;
      if (mem_done_out !== 1'b1 || ram_wr_out !== 1'b0 || busy_out !== 2'b00)
         begin miscompares++; $display("[TB] FAIL sb_done got done=%b wr=%b busy=%b want 1/0/00", mem_done_out, ram_wr_out, busy_out); end
      mem_req_in = 1'b0;
      ref_mem[32'h3] = 8'hAB;
      tick();
   endtask

   task automatic test_mem_random();
      logic [31:0] a, wd, exp;
      logic [1:0]  sz;
      logic        we;
      int n, cyc;
      bit got;
      for (int t = 0; t < 24; t++) begin
         we = 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         a  = (t % 6 == 5) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 255));
         wd = $urandom;
         n  = len_of(sz);
         exp = ref_load(a, n);
         if (we) for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
         mem_we_in = we; mem_size_in = sz; mem_addr_in = a; mem_wdata_in = wd;
         mem_req_in = 1'b1;
         cyc = 0;
         got = 1'b0;
         while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (mem_done_out) begin
               got = 1'b1;
               mem_req_in = 1'b0;
            end else begin
               vectors++;
               if (busy_out !== 2'b01 || mem_rdata_out !== 32'h0)
                  begin miscompares++; $display("[TB] FAIL mem_busy cyc %0d got %b/%h want 01/0", cyc, busy_out, mem_rdata_out); end
               vectors++;
               if (cyc <= n) begin
                  if (ram_a_out !== a + 32'(cyc - 1) || ram_wr_out !== we || (we && ram_dout_out !== wd[8*(cyc-1) +: 8]))
                     begin miscompares++; $display("[TB] FAIL mem_ram_drive got a=%h wr=%b d=%h want a=%h wr=%b", ram_a_out, ram_wr_out, ram_dout_out, a + 32'(cyc - 1), we); end
               end else if (ram_a_out !== 32'h0 || ram_wr_out !== 1'b0) begin
                  miscompares++; $display("[TB] FAIL mem_ram_quiet got a=%h wr=%b want 0/0", ram_a_out, ram_wr_out);
               end
            end
         end
         mem_req_in = 1'b0;
         vectors++;
         if (!got || cyc != (we ? n + 1 : n + 2))
            begin miscompares++; $display("[TB] FAIL mem_latency got %0d want %0d", cyc, we ? n + 1 : n + 2); end
         if (!we) begin
            vectors++;
            if (mem_rdata_out !== exp) begin miscompares++; $display("[TB] FAIL mem_load got %h want %h", mem_rdata_out, exp); end
         end
      end
      tick();
      foreach (ref_mem[k]) begin
         vectors++;
         if (ram_rd(k) !== ref_mem[k]) begin miscompares++; $display("[TB] FAIL ram_contents @%h got %h want %h", k, ram_rd(k), ref_mem[k]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_m, exp_i;
      int mem_cnt, if_cnt, mem_cyc, if_cyc;
      for (int k = 0; k < 4; k++) preload(32'h2000 + 32'(k), 8'($urandom));
      exp_m = ref_load(32'h2000, 4);
      exp_i = ref_load(32'h1000, 4);
      mem_cnt = 0; if_cnt = 0; mem_cyc = 0; if_cyc = 0;
      mem_we_in = 1'b0; mem_size_in = 2'd2; mem_addr_in = 32'h2000;
      if_addr_in = 32'h1000;
      mem_req_in = 1'b1;
      if_req_in  = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         if (cyc == 1) begin
            vectors++;
            if (busy_out !== 2'b01) begin miscompares++; $display("[TB] FAIL arb_first got %b want 01", busy_out); end
         end
         vectors++;
         if ((mem_done_out && busy_out[0]) || (inst_done_out && busy_out[1]))
            begin miscompares++; $display("[TB] FAIL arb_done_busy cyc %0d got busy=%b with done", cyc, busy_out); end
         if (mem_done_out) begin
            mem_cnt++; mem_cyc = cyc; mem_req_in = 1'b0;
            vectors++;
            if (mem_rdata_out !== exp_m) begin miscompares++; $display("[TB] FAIL arb_mem_data got %h want %h", mem_rdata_out, exp_m); end
         end
         if (inst_done_out) begin
            if_cnt++; if_cyc = cyc; if_req_in = 1'b0;
            vectors++;
            if (inst_out !== exp_i) begin miscompares++; $display("[TB] FAIL arb_if_data got %h want %h", inst_out, exp_i); end
         end
      end
      mem_req_in = 1'b0;
      if_req_in  = 1'b0;
      vectors++;
      if (mem_cnt != 1 || if_cnt != 1) begin miscompares++; $display("[TB] FAIL arb_counts got %0d/%0d want 1/1", mem_cnt, if_cnt); end
      vectors++;
      if (mem_cyc != 6 || if_cyc != 12) begin miscompares++; $display("[TB] FAIL arb_order got %0d/%0d want 6/12", mem_cyc, if_cyc); end
   endtask

   task automatic test_branch();
      bit seen;
      bit got;
      int cyc;
      if_addr_in = 32'h1000;
      if_req_in  = 1'b1;
      tick();
      vectors++;
      if (busy_out !== 2'b10) begin miscompares++; $display("[TB] FAIL br_start got %b want 10", busy_out); end
      tick();
      branch_flag_in = 1'b1;
      if_req_in      = 1'b0;
      tick();
      branch_flag_in = 1'b0;
      vectors++;
      if (busy_out !== 2'b00 || inst_done_out !== 1'b0)
         begin miscompares++; $display("[TB] FAIL br_abort got busy=%b done=%b want 00/0", busy_out, inst_done_out); end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (inst_done_out) seen = 1'b1;
      end
      vectors++;
      if (seen) begin miscompares++; $display("[TB] FAIL br_no_done got done=1 want 0"); end
      if_req_in      = 1'b1;
      branch_flag_in = 1'b1;
      tick();
      branch_flag_in = 1'b0;
      vectors++;
      if (busy_out !== 2'b00) begin miscompares++; $display("[TB] FAIL br_idle_suppress got %b want 00", busy_out); end
      tick();
      vectors++;
      if (busy_out !== 2'b10) begin miscompares++; $display("[TB] FAIL br_accept got %b want 10", busy_out); end
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         if (inst_done_out) begin got = 1'b1; if_req_in = 1'b0; end
      end
      if_req_in = 1'b0;
      vectors++;
      if (!got || cyc != 6 || inst_out !== ref_load(32'h1000, 4))
         begin miscompares++; $display("[TB] FAIL br_refetch got cyc=%0d data=%h want 6/%h", cyc, inst_out, ref_load(32'h1000, 4)); end
      tick();
   endtask

   task automatic test_reset_mid_write();
      int cyc;
      bit got;
      mem_we_in = 1'b1; mem_size_in = 2'd2; mem_addr_in = 32'h100; mem_wdata_in = $urandom;
      mem_req_in = 1'b1;
      tick();
      tick();
      vectors++;
      if (ram_wr_out !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre got wr=%b want 1", ram_wr_out); end
      #2 rst_in = 1'b0;
      #1;
      vectors++;
      if ({inst_out, inst_done_out, mem_rdata_out, mem_done_out, busy_out, ram_dout_out, ram_a_out, ram_wr_out} !== '0)
         begin miscompares++; $display("[TB] FAIL rst_mid got busy=%b a=%h wr=%b d=%h want all zero", busy_out, ram_a_out, ram_wr_out, ram_dout_out); end
      mem_req_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
      mem_we_in = 1'b0; mem_size_in = 2'd0; mem_addr_in = 32'h3;
      mem_req_in = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         if (mem_done_out) begin got = 1'b1; mem_req_in = 1'b0; end
      end
      mem_req_in = 1'b0;
      vectors++;
      if (!got || cyc != 3 || mem_rdata_out !== 32'h0000_00AB)
         begin miscompares++; $display("[TB] FAIL rst_recover got cyc=%0d data=%h want 3/000000ab", cyc, mem_rdata_out); end
      tick();
   endtask

   task automatic test_io_full();
      logic [31:0] wd;
      int cyc;
      bit got;
      wd = $urandom;
      mem_we_in = 1'b1; mem_size_in = 2'd2; mem_addr_in = 32'h0003_0000; mem_wdata_in = wd;
      mem_req_in = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         io_full_in = (cyc >= 2 && cyc <= 4);
         #1;
         if (mem_done_out) begin got = 1'b1; mem_req_in = 1'b0; io_full_in = 1'b0; end
         else if (cyc == 2) begin
            vectors++;
            if (ram_wr_out !== !IO_EN) begin miscompares++; $display("[TB] FAIL io_stall_wr got %b want %b", ram_wr_out, !IO_EN); end
         end
      end
      mem_req_in = 1'b0;
      io_full_in = 1'b0;
      vectors++;
      if (!got || cyc != (IO_EN ? 8 : 5)) begin miscompares++; $display("[TB] FAIL io_latency got %0d want %0d", cyc, IO_EN ? 8 : 5); end
      tick();
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (ram_rd(32'h0003_0000 + 32'(k)) !== wd[8*k +: 8])
            begin miscompares++; $display("[TB] FAIL io_data byte %0d got %h want %h", k, ram_rd(32'h0003_0000 + 32'(k)), wd[8*k +: 8]); end
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_store_byte();
      test_mem_random();
      test_back_to_back();
      test_branch();
      test_reset_mid_write();
      test_io_full();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
